// File: rtl/ttl_shift_reg_univ.sv
// Parametrised 74194-style universal shift register (hold / shift-right / shift-left / load)
// with a shift counter and a one-period word-ready pulse for serial-to-parallel deserialising.
module ttl_shift_reg_univ #(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter bit               WRAP    = 1'b0,
  parameter int               MRDLY   = 24,
  parameter int               REGDLY  = 19
) (
  input  logic                         clk,
  input  logic                         MRn,
  input  logic                         CEn,
  input  logic [1:0]                   S,
  input  logic                         A,
  input  logic                         B,
  input  logic                         DSL,
  input  logic [WIDTH-1:0]             D,
  output logic [WIDTH-1:0]             Q,
  output logic                         QSR,
  output logic                         QSL,
  output logic [$clog2(WIDTH+1)-1:0]   CNT,
  output logic                         WRDY
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_SHR   = 2'b01;
  localparam logic [1:0] MODE_SHL   = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  // Delays only shape the behavioural timing model; the RTL is zero-delay.
  if (WIDTH < 2 || WIDTH > 32 || MRDLY < 0 || REGDLY < 0) begin : g_param_check
    $error("ttl_shift_reg_univ: illegal parameter set");
  end

  logic [WIDTH-1:0] q_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic             wrdy_nxt;
  logic             shift;

  // Next-state: mode decode, then counter / word-ready on any shift.
  always_comb begin
    q_nxt    = Q;
    cnt_nxt  = CNT;
    wrdy_nxt = 1'b0;
    shift    = 1'b0;
    case (S)
      MODE_SHR: begin
        q_nxt = {Q[WIDTH-2:0], A & B};
        shift = 1'b1;
      end
      MODE_SHL: begin
        q_nxt = {DSL, Q[WIDTH-1:1]};
        shift = 1'b1;
      end
      MODE_LOAD: begin
        q_nxt   = D;
        cnt_nxt = '0;
      end
      MODE_HOLD: ;
      default: ;
    endcase
    if (shift) begin
      if (WRAP) begin
        if (CNT == CW'(WIDTH - 1)) begin
          cnt_nxt  = '0;
          wrdy_nxt = 1'b1;
        end else begin
          cnt_nxt = CNT + CW'(1);
        end
      end else if (CNT != CW'(WIDTH)) begin
        // Saturating: once full, further shifts neither count nor pulse.
        cnt_nxt  = CNT + CW'(1);
        wrdy_nxt = (CNT == CW'(WIDTH - 1));
      end
    end
  end

  // State register; CEn high freezes everything including a pending WRDY.
  always_ff @(posedge clk or negedge MRn) begin
    if (!MRn) begin
      Q    <= RST_VAL;
      CNT  <= '0;
      WRDY <= 1'b0;
    end else if (!CEn) begin
      Q    <= q_nxt;
      CNT  <= cnt_nxt;
      WRDY <= wrdy_nxt;
    end
  end

  assign QSR = Q[WIDTH-1];
  assign QSL = Q[0];

endmodule

// File: tb/tb_ttl_shift_reg_univ.sv
// Scoreboard bench for ttl_shift_reg_univ: saturating (u0) and wrapping (u1) instances,
// directed stimulus pushes expected state, monitors pop and compare.
module tb_ttl_shift_reg_univ;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 4;

  typedef struct {
    string          name;
    bit             async;
    bit             sel;
    logic [W-1:0]   q;
    logic [CW-1:0]  cnt;
    logic           wrdy;
  } exp_t;

  logic          clk = 1'b0;
  logic          mrn, cen, a, b, dsl;
  logic [1:0]    s;
  logic [W-1:0]  d;

  logic [W-1:0]  q0, q1;
  logic [CW-1:0] cnt0, cnt1;
  logic          wrdy0, wrdy1, qsr0, qsr1, qsl0, qsl1;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  event check_now;

  bit         t2_b [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [7:0] t2_q [8] = '{8'h05, 8'h0B, 8'h16, 8'h2C, 8'h59, 8'hB3, 8'h66, 8'hCD};
  logic [7:0] t4_q [5] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F};
  logic [7:0] t6_q [6] = '{8'hB5, 8'h6B, 8'hD7, 8'hAF, 8'h5F, 8'hBF};

  ttl_shift_reg_univ #(.WIDTH(W), .RST_VAL(8'h02), .WRAP(1'b0), .MRDLY(24), .REGDLY(19)) u0 (
    .clk(clk), .MRn(mrn), .CEn(cen), .S(s), .A(a), .B(b), .DSL(dsl), .D(d),
    .Q(q0), .QSR(qsr0), .QSL(qsl0), .CNT(cnt0), .WRDY(wrdy0)
  );

  ttl_shift_reg_univ #(.WIDTH(W), .RST_VAL(8'h02), .WRAP(1'b1), .MRDLY(24), .REGDLY(19)) u1 (
    .clk(clk), .MRn(mrn), .CEn(cen), .S(s), .A(a), .B(b), .DSL(dsl), .D(d),
    .Q(q1), .QSR(qsr1), .QSL(qsl1), .CNT(cnt1), .WRDY(wrdy1)
  );

  always #50 clk = ~clk;

  task automatic cmp(input string nm, input string field, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s at %0t: got %h expected %h", nm, field, $time, act, exp);
    end
  endtask

  task automatic check_entry(input exp_t e);
    logic [W-1:0]  q;
    logic [CW-1:0] c;
    logic          w, sr, sl;
    q  = e.sel ? q1 : q0;
    c  = e.sel ? cnt1 : cnt0;
    w  = e.sel ? wrdy1 : wrdy0;
    sr = e.sel ? qsr1 : qsr0;
    sl = e.sel ? qsl1 : qsl0;
    cmp(e.name, "Q",    q,        e.q);
    cmp(e.name, "CNT",  8'(c),    8'(e.cnt));
    cmp(e.name, "WRDY", 8'(w),    8'(e.wrdy));
    cmp(e.name, "QSR",  8'(sr),   8'(e.q[W-1]));
    cmp(e.name, "QSL",  8'(sl),   8'(e.q[0]));
  endtask

  // Clocked monitor: expectations for the edge just taken.
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && !sb[0].async) check_entry(sb.pop_front());
    end
  end

  // Asynchronous monitor: reset effects checked without any clock edge.
  initial begin
    forever begin
      @(check_now);
      while (sb.size() > 0 && sb[0].async) check_entry(sb.pop_front());
    end
  end

  task automatic push(input string nm, input bit as, input bit sel,
                      input logic [7:0] q, input logic [3:0] c, input logic w);
    exp_t e;
    e.name = nm; e.async = as; e.sel = sel; e.q = q; e.cnt = c; e.wrdy = w;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [1:0] s_i, input logic a_i, input logic b_i,
                       input logic dsl_i, input logic [7:0] d_i, input logic cen_i);
    @(negedge clk);
    #1;
    s = s_i; a = a_i; b = b_i; dsl = dsl_i; d = d_i; cen = cen_i;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: run did not finish, time %0t required below 50000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    mrn = 1'b1; cen = 1'b1; s = 2'b00; a = 1'b0; b = 1'b0; dsl = 1'b0; d = '0;

    // Reset asserted at 100 ns, checked 24 ns later with no clock edge in between.
    #100 mrn = 1'b0;
    #1;
    push("t1_reset", 1'b1, 1'b0, 8'h02, 4'd0, 1'b0);
    push("t1_reset_w", 1'b1, 1'b1, 8'h02, 4'd0, 1'b0);
    #23 -> check_now;
    #6 mrn = 1'b1;
    drive(2'b00, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0);
    push("t1_hold", 1'b0, 1'b0, 8'h02, 4'd0, 1'b0);

    // Shift right with A&B gating; word completes on the 8th shift.
    for (int i = 0; i < 8; i++) begin
      drive(2'b01, 1'b1, t2_b[i], 1'b0, 8'h00, 1'b0);
      push("t2_shr", 1'b0, 1'b0, t2_q[i], 4'(i + 1), (i == 7));
    end
    drive(2'b01, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    push("t2_sat", 1'b0, 1'b0, 8'h9A, 4'd8, 1'b0);

    // Load then shift left.
    drive(2'b11, 1'b0, 1'b0, 1'b0, 8'h81, 1'b0);
    push("t3_load", 1'b0, 1'b0, 8'h81, 4'd0, 1'b0);
    drive(2'b10, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    push("t3_shl1", 1'b0, 1'b0, 8'h40, 4'd1, 1'b0);
    drive(2'b10, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    push("t3_shl2", 1'b0, 1'b0, 8'h20, 4'd2, 1'b0);

    // Clock enable freeze mid-word, then finish the word.
    drive(2'b11, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    push("t4_load", 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(2'b01, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
      push("t4_fill", 1'b0, 1'b0, t4_q[i], 4'(i + 1), 1'b0);
    end
    for (int i = 0; i < 10; i++) begin
      drive(2'b01, 1'b1, i[0], ~i[0], 8'(i * 37), 1'b1);
      push("t4_cen_hold", 1'b0, 1'b0, 8'h1F, 4'd5, 1'b0);
    end
    drive(2'b01, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    push("t4_resume6", 1'b0, 1'b0, 8'h3E, 4'd6, 1'b0);
    drive(2'b01, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    push("t4_resume7", 1'b0, 1'b0, 8'h7C, 4'd7, 1'b0);
    drive(2'b01, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    push("t4_resume8", 1'b0, 1'b0, 8'hF8, 4'd8, 1'b1);
    drive(2'b01, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
    push("t4_wrdy_held", 1'b0, 1'b0, 8'hF8, 4'd8, 1'b1);
    drive(2'b11, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0);
    push("t4_load_after", 1'b0, 1'b0, 8'h5A, 4'd0, 1'b0);

    // Async reset at CNT=6 discards the partial word.
    for (int i = 0; i < 6; i++) begin
      drive(2'b01, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
      push("t6_shift", 1'b0, 1'b0, t6_q[i], 4'(i + 1), 1'b0);
    end
    @(negedge clk);
    #5 mrn = 1'b0;
    #1;
    push("t6_async", 1'b1, 1'b0, 8'h02, 4'd0, 1'b0);
    #23 -> check_now;
    drive(2'b11, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0);
    push("t6_held", 1'b0, 1'b0, 8'h02, 4'd0, 1'b0);
    @(posedge clk);
    #10 mrn = 1'b1;
    drive(2'b01, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    push("t6_restart1", 1'b0, 1'b0, 8'h05, 4'd1, 1'b0);
    drive(2'b01, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    push("t6_restart2", 1'b0, 1'b0, 8'h0A, 4'd2, 1'b0);

    // Wrapping instance: 24 shifts give pulses after 8, 16, 24.
    drive(2'b11, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    push("t5_load", 1'b0, 1'b1, 8'h00, 4'd0, 1'b0);
    for (int k = 1; k <= 24; k++) begin
      drive(2'b01, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
      push("t5_wrap", 1'b0, 1'b1, (k >= 8) ? 8'hFF : 8'((1 << k) - 1), 4'(k % 8), (k % 8 == 0));
    end

    @(negedge clk);
    #1;
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ttl_shift_reg_univ.md
Name: ttl_shift_reg_univ

Overview:
- Parametrised universal shift register. It is the successor to the fixed 4-bit serial-in/parallel-out TTL model.
- Width, reset pattern and propagation delays are generic. Modes are hold, shift-right, shift-left and parallel load, selected by S1/S0 in the 74194 style.
- A shift counter and a word-ready pulse support serial-to-parallel deserialisation, for example sprite/tile pixel-shifter chains in the board models.
- Sits alongside the other TTL behavioural models and is instantiated wherever chained 74164/74194/74299 parts appear on the schematics.

Parameters:
- WIDTH, 8, register length in bits; legal range 2..32.
- RST_VAL, 0, WIDTH-bit pattern loaded into Q on reset. Some boards wire nonzero power-on patterns.
- WRAP, 0: 0 = counter saturates at WIDTH; 1 = counter wraps, giving a continuous word stream.
- MRDLY, 24, MRn-to-Q delay in ns (simulation only).
- REGDLY, 19, clk-to-Q delay in ns (simulation only).

Ports:
- clk  in  1  shift clock (CP), rising-edge active.
- MRn  in  1  master reset.
- CEn  in  1  clock enable, active low; when 1, all state holds.
- S  in  2  mode select {S1,S0}.
- A  in  1  serial-right data gate input.
- B  in  1  serial-right data gate input.
- DSL  in  1  serial-left data input.
- D  in  WIDTH  parallel load data.
- Q  out  WIDTH  register contents, Q[0] is the first stage.
- QSR  out  1  serial-right output = Q[WIDTH-1].
- QSL  out  1  serial-left output = Q[0].
- CNT  out  $clog2(WIDTH+1)  shifts since last reset/load.
- WRDY  out  1  word-ready pulse.

Interface (already decided): one clock, clk. Reset MRn is asynchronous and active-low.

Behaviour:
- Reset (MRn=0, asynchronous, overrides everything): Q=RST_VAL, CNT=0, WRDY=0, all after MRDLY.
  - Held while MRn=0.
  - Release is synchronous-safe: the first active edge after MRn rises operates normally.
- Reset mid-shift discards the partial word. No WRDY is produced for it.
- On rising clk with MRn=1 and CEn=0, the mode is selected by S:
  - 00 hold: Q and CNT are unchanged.
  - 01 shift right: Q[0]<=A&B; Q[i]<=Q[i-1] for i>=1; Q[WIDTH-1] falls out via QSR.
  - 10 shift left: Q[WIDTH-1]<=DSL; Q[i]<=Q[i+1] for i<WIDTH-1.
  - 11 parallel load: Q<=D and CNT<=0.
- CEn=1: Q, CNT and WRDY all hold. WRDY holds its value, so WRDY high remains high until the next enabled edge.
- Counter on a shift (01 or 10):
  - WRAP=0: CNT increments, saturating at WIDTH.
  - WRAP=1: CNT counts 0..WIDTH-1 and wraps to 0.
- WRDY: registered, high for exactly one enabled clock period.
  - Set by the enabled shift that completes a word: CNT WIDTH-1 -> WIDTH when WRAP=0, or WIDTH-1 -> 0 when WRAP=1.
  - Cleared by the next enabled edge of any mode.
  - With WRAP=0, shifts while CNT=WIDTH never pulse again.
  - A load on the edge after the pulse clears both WRDY and CNT.
- Load and shift are mutually exclusive by encoding. No simultaneous-event priority exists other than reset > CEn > S.
- QSR and QSL are combinational from Q and carry no extra delay.
- All clocked updates use REGDLY. Delays are ignored by synthesis, and the zero-delay RTL must be functionally identical.

Test Plan (WIDTH=8, RST_VAL=8'h02, WRAP=0 unless stated):
1. Reset: MRn=0 at t=100ns.
   - Q=8'h02 and CNT=0 at 124ns, WRDY=0.
   - Then release MRn; a clk edge with S=00 leaves Q=8'h02.
2. Shift-right and gating: S=01, A=1, then B pattern 1,0,1,1,0,0,1,1 (LSB stage first).
   - After 8 edges Q=8'b11001101.
   - WRDY high for one cycle exactly after the 8th edge; CNT=8.
   - A 9th shift keeps CNT=8 and WRDY=0.
3. Shift-left: load D=8'h81 (S=11), then S=10, DSL=0, two edges.
   - Q=8'h20.
   - QSL tracks Q[0]; CNT=2 after the shifts.
4. Clock enable: mid-word at CNT=5, hold CEn=1 for 10 edges with S=01 toggling data.
   - Q and CNT are unchanged.
   - Resume CEn=0; WRDY fires after 3 further shifts.
5. Wrap mode (WRAP=1): 24 consecutive right shifts.
   - WRDY pulses after shifts 8, 16 and 24.
   - CNT returns to 0 at each pulse.
6. Asynchronous reset mid-operation: assert MRn=0 between clk edges at CNT=6.
   - Q=8'h02 and CNT=0 after 24ns with no clk edge.
   - No WRDY pulse for the partial word.
